// File: rtl/uart_pkg.sv
// Shared types for the parameterised UART transmitter: parity modes, FSM state
// encoding and the frame parity helper.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t START = 3'd1;
    localparam state_t DATA  = 3'd2;
    localparam state_t PAR   = 3'd3;
    localparam state_t STOP  = 3'd4;

    // Bit sent in the parity slot: XOR of the low nbits payload bits, inverted for odd.
    function automatic logic parity_bit(input logic [7:0] data, input int nbits,
                                        input parity_e mode);
        logic x;
        x = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < nbits) x = x ^ data[i];
        end
        return (mode == PAR_ODD) ? ~x : x;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data and an occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    // A push at full is dropped even when a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;

endmodule

// File: rtl/uart_tx_param.sv
// Buffered UART transmitter: bytes queue in a FIFO and are framed as start,
// DATA_BITS payload LSB first, optional parity, STOP_BITS stop bits.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int      CLK_DIV    = 868,
    parameter int      DATA_BITS  = 8,
    parameter parity_e PARITY     = PAR_NONE,
    parameter int      STOP_BITS  = 1,
    parameter int      FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  wr_data,
    input  logic                        wr_en,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        txd,
    output logic                        busy
);

    localparam int                BAUD_W    = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    state_t                 state_q, state_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   txd_q, txd_d;
    logic                   baud_last;
    logic                   start_frame;
    logic [DATA_BITS-1:0]   fifo_rdata;
    logic [7:0]             rd_byte;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .wdata (wr_data[DATA_BITS-1:0]),
        .pop   (start_frame),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign rd_byte   = 8'(fifo_rdata);
    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_d       = par_q;
        txd_d       = txd_q;
        start_frame = 1'b0;
        baud_d      = (state_q == IDLE || baud_last) ? '0 : baud_q + BAUD_W'(1);

        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (!empty) start_frame = 1'b1;
            end
            START: begin
                if (baud_last) begin
                    state_d = DATA;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                end
            end
            DATA: begin
                if (baud_last) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY != PAR_NONE) begin
                            state_d = PAR;
                            txd_d   = par_q;
                        end else begin
                            state_d = STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        txd_d   = shift_d[0];
                    end
                end
            end
            PAR: begin
                if (baud_last) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        // Chain straight into the next frame when data is waiting.
                        if (!empty) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = IDLE;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase

        if (start_frame) begin
            state_d = START;
            txd_d   = 1'b0;
            shift_d = fifo_rdata;
            par_d   = parity_bit(rd_byte, DATA_BITS, PARITY);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            txd_q   <= txd_d;
        end
    end

    // Payload and parity are only consumed after a load, so they carry no reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    assign txd  = txd_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench: several uart_tx_param configurations checked against a
// frame-level model (bit lists per byte, FIFO occupancy as a queue).
module tb_uart_tx_param;
    import uart_pkg::*;

    localparam int N = 6;
    localparam int      CDIV  [N] = '{4, 4, 4, 3, 4, 2};
    localparam int      DBITS [N] = '{8, 8, 8, 7, 8, 5};
    localparam int      SBITS [N] = '{1, 1, 1, 2, 1, 2};
    localparam int      DEPTH [N] = '{16, 16, 16, 16, 4, 2};
    localparam parity_e PMODE [N] = '{PAR_NONE, PAR_EVEN, PAR_ODD, PAR_NONE, PAR_NONE, PAR_ODD};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] wr_data [N];
    logic       wr_en   [N];
    logic       full_w  [N];
    logic       empty_w [N];
    logic       txd_w   [N];
    logic       busy_w  [N];
    logic [4:0] lvl0, lvl1, lvl2, lvl3;
    logic [2:0] lvl4;
    logic [1:0] lvl5;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut0 (
        .clk(clk), .rst(rst), .wr_data(wr_data[0]), .wr_en(wr_en[0]), .full(full_w[0]),
        .empty(empty_w[0]), .level(lvl0), .txd(txd_w[0]), .busy(busy_w[0]));
    uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut1 (
        .clk(clk), .rst(rst), .wr_data(wr_data[1]), .wr_en(wr_en[1]), .full(full_w[1]),
        .empty(empty_w[1]), .level(lvl1), .txd(txd_w[1]), .busy(busy_w[1]));
    uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut2 (
        .clk(clk), .rst(rst), .wr_data(wr_data[2]), .wr_en(wr_en[2]), .full(full_w[2]),
        .empty(empty_w[2]), .level(lvl2), .txd(txd_w[2]), .busy(busy_w[2]));
    uart_tx_param #(.CLK_DIV(3), .DATA_BITS(7), .PARITY(PAR_NONE), .STOP_BITS(2), .FIFO_DEPTH(16)) u_dut3 (
        .clk(clk), .rst(rst), .wr_data(wr_data[3]), .wr_en(wr_en[3]), .full(full_w[3]),
        .empty(empty_w[3]), .level(lvl3), .txd(txd_w[3]), .busy(busy_w[3]));
    uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .wr_data(wr_data[4]), .wr_en(wr_en[4]), .full(full_w[4]),
        .empty(empty_w[4]), .level(lvl4), .txd(txd_w[4]), .busy(busy_w[4]));
    uart_tx_param #(.CLK_DIV(2), .DATA_BITS(5), .PARITY(PAR_ODD), .STOP_BITS(2), .FIFO_DEPTH(2)) u_dut5 (
        .clk(clk), .rst(rst), .wr_data(wr_data[5]), .wr_en(wr_en[5]), .full(full_w[5]),
        .empty(empty_w[5]), .level(lvl5), .txd(txd_w[5]), .busy(busy_w[5]));

    function automatic int lvl(input int k);
        case (k)
            0:       return int'(lvl0);
            1:       return int'(lvl1);
            2:       return int'(lvl2);
            3:       return int'(lvl3);
            4:       return int'(lvl4);
            default: return int'(lvl5);
        endcase
    endfunction

    function automatic int frame_len(input int k);
        return 1 + DBITS[k] + ((PMODE[k] == PAR_NONE) ? 0 : 1) + SBITS[k];
    endfunction

    // Line value for slot idx of the frame carrying byte b on instance k.
    function automatic logic frame_bit(input int k, input logic [7:0] b, input int idx);
        int ones;
        ones = 0;
        for (int i = 0; i < DBITS[k]; i++) ones += int'(b[i]);
        if (idx == 0) return 1'b0;
        if (idx <= DBITS[k]) return b[idx-1];
        if (PMODE[k] != PAR_NONE && idx == DBITS[k] + 1)
            return (PMODE[k] == PAR_EVEN) ? (ones % 2 == 1) : (ones % 2 == 0);
        return 1'b1;
    endfunction

    // Called and returning on a falling clock edge.
    task automatic write_byte(input int k, input logic [7:0] b);
        wr_data[k] = b;
        wr_en[k]   = 1'b1;
        @(negedge clk);
        wr_en[k]   = 1'b0;
    endtask

    // Waits (bounded) for the start bit, then checks every slot for exactly CDIV cycles.
    task automatic check_frame(input int k, input logic [7:0] b, input string name, output int waited);
        int busy_cnt;
        busy_cnt = 0;
        waited   = 0;
        while (txd_w[k] !== 1'b0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        n_tests++;
        if (txd_w[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start: txd=%b after %0d cycles, required 0", name, txd_w[k], waited);
            return;
        end
        for (int idx = 0; idx < frame_len(k); idx++) begin
            logic exp;
            int   nbad;
            exp  = frame_bit(k, b, idx);
            nbad = 0;
            for (int c = 0; c < CDIV[k]; c++) begin
                if (!(idx == 0 && c == 0)) @(negedge clk);
                if (txd_w[k] !== exp) nbad++;
                if (busy_w[k] === 1'b1) busy_cnt++;
            end
            n_tests++;
            if (nbad != 0) begin
                n_fail++;
                $display("FAIL %s slot %0d: txd wrong in %0d of %0d cycles, required %b",
                         name, idx, nbad, CDIV[k], exp);
            end
        end
        n_tests++;
        if (busy_cnt != frame_len(k) * CDIV[k]) begin
            n_fail++;
            $display("FAIL %s busy: high %0d cycles, required %0d", name, busy_cnt, frame_len(k) * CDIV[k]);
        end
    endtask

    task automatic check_idle(input int k, input string name);
        @(negedge clk);
        n_tests++;
        if (txd_w[k] !== 1'b1 || busy_w[k] !== 1'b0 || empty_w[k] !== 1'b1 || lvl(k) != 0) begin
            n_fail++;
            $display("FAIL %s idle: txd=%b busy=%b empty=%b level=%0d, required 1 0 1 0",
                     name, txd_w[k], busy_w[k], empty_w[k], lvl(k));
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if (txd_w[k] !== 1'b1 || busy_w[k] !== 1'b0 || empty_w[k] !== 1'b1 ||
                full_w[k] !== 1'b0 || lvl(k) != 0) begin
                n_fail++;
                $display("FAIL reset_k%0d: txd=%b busy=%b empty=%b full=%b level=%0d, required 1 0 1 0 0",
                         k, txd_w[k], busy_w[k], empty_w[k], full_w[k], lvl(k));
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_8n1();
        int w;
        write_byte(0, 8'hA5);
        n_tests++;
        if (lvl(0) != 1 || empty_w[0] !== 1'b0 || txd_w[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL push_8n1: level=%0d empty=%b txd=%b, required 1 0 1", lvl(0), empty_w[0], txd_w[0]);
        end
        check_frame(0, 8'hA5, "8n1_a5", w);
        n_tests++;
        if (w != 1) begin
            n_fail++;
            $display("FAIL start_latency_8n1: start after %0d cycles, required 1", w);
        end
        check_idle(0, "8n1_a5");
    endtask

    task automatic test_parity();
        int w;
        for (int k = 1; k <= 2; k++) begin
            write_byte(k, 8'hA5);
            check_frame(k, 8'hA5, $sformatf("parity_k%0d_a5", k), w);
            check_idle(k, $sformatf("parity_k%0d_a5", k));
        end
    endtask

    task automatic test_7bit_2stop();
        int w;
        write_byte(3, 8'hFF);
        check_frame(3, 8'hFF, "7n2_ff", w);
        check_idle(3, "7n2_ff");
    endtask

    task automatic test_random();
        int ks [5] = '{0, 1, 2, 3, 5};
        int w;
        logic [7:0] b;
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 5; j++) begin
                b = 8'($urandom);
                write_byte(ks[j], b);
                check_frame(ks[j], b, $sformatf("rand_k%0d_%02h", ks[j], b), w);
                check_idle(ks[j], $sformatf("rand_k%0d", ks[j]));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] data_v [6];
        int         exp_lvl [6];
        logic       exp_full [6];
        logic [7:0] q [$];
        logic [7:0] frames [$];
        bit         idle;
        int         quiet_bad;
        for (int i = 0; i < 6; i++) data_v[i] = 8'($urandom);
        // Model: the idle transmitter takes one entry the cycle after it sees data.
        idle = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bit do_pop, do_push;
            do_pop  = idle && q.size() > 0;
            do_push = q.size() < DEPTH[4];
            if (do_pop) begin
                frames.push_back(q.pop_front());
                idle = 1'b0;
            end
            if (do_push) q.push_back(data_v[i]);
            exp_lvl[i]  = q.size();
            exp_full[i] = (q.size() == DEPTH[4]);
        end
        while (q.size() > 0) frames.push_back(q.pop_front());

        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    wr_data[4] = data_v[i];
                    wr_en[4]   = 1'b1;
                    @(negedge clk);
                    n_tests++;
                    if (lvl(4) != exp_lvl[i] || full_w[4] !== exp_full[i]) begin
                        n_fail++;
                        $display("FAIL b2b_write%0d: level=%0d full=%b, required %0d %b",
                                 i, lvl(4), full_w[4], exp_lvl[i], exp_full[i]);
                    end
                end
                wr_en[4] = 1'b0;
            end
            begin
                int w;
                for (int f = 0; f < frames.size(); f++) begin
                    check_frame(4, frames[f], $sformatf("b2b_frame%0d", f), w);
                    if (f > 0) begin
                        n_tests++;
                        if (w != 1) begin
                            n_fail++;
                            $display("FAIL b2b_gap%0d: start after %0d cycles, required 1", f, w);
                        end
                    end
                end
            end
        join
        check_idle(4, "b2b");
        quiet_bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (txd_w[4] !== 1'b1 || busy_w[4] !== 1'b0) quiet_bad++;
        end
        n_tests++;
        if (quiet_bad != 0) begin
            n_fail++;
            $display("FAIL b2b_dropped: line active in %0d of 12 cycles, required 0", quiet_bad);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        int w;
        b = 8'($urandom);
        write_byte(0, b);
        write_byte(0, 8'h55);
        n_tests++;
        if (txd_w[0] !== 1'b0 || lvl(0) != 1) begin
            n_fail++;
            $display("FAIL mid_pre: txd=%b level=%0d, required 0 1", txd_w[0], lvl(0));
        end
        repeat (4 * CDIV[0]) @(negedge clk);
        n_tests++;
        if (txd_w[0] !== b[3]) begin
            n_fail++;
            $display("FAIL mid_bit3: txd=%b, required %b", txd_w[0], b[3]);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (txd_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || lvl(0) != 0 || empty_w[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: txd=%b busy=%b level=%0d empty=%b, required 1 0 0 1",
                     txd_w[0], busy_w[0], lvl(0), empty_w[0]);
        end
        rst = 1'b1;
        write_byte(0, 8'h3C);
        check_frame(0, 8'h3C, "after_reset_3c", w);
        n_tests++;
        if (w != 1) begin
            n_fail++;
            $display("FAIL after_reset_latency: start after %0d cycles, required 1", w);
        end
        check_idle(0, "after_reset_3c");
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            wr_data[k] = 8'h00;
            wr_en[k]   = 1'b0;
        end
        test_reset();
        test_8n1();
        test_parity();
        test_7bit_2stop();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
